// File: rtl/clkgen_pkg.sv
// clkgen_pkg: shared types and helpers for the clock-strobe generator.
package clkgen_pkg;

    typedef enum logic [1:0] {WAIT_LOCK, COUNT, RUN} state_t;

    // Increment that yields f_out strobes from an f_in clock with an acc_w-bit accumulator
    function automatic longint unsigned freq_to_inc(
        input longint unsigned f_out,
        input longint unsigned f_in,
        input int unsigned     acc_w
    );
        return (f_out << acc_w) / f_in;
    endfunction

endpackage

// File: rtl/clk_strobe_gen_phase_acc.sv
// phase_acc: one fractional-rate strobe channel; the accumulator carry-out is the strobe.
module phase_acc
    import clkgen_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_align,
    input  logic             i_inc_we,
    input  logic [ACC_W-1:0] i_inc,
    output logic             o_ce
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc;
    logic             r_ce;
    logic [ACC_W:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};
    assign o_ce  = r_ce;

    // A freshly loaded increment is only seen by the accumulate on the following edge
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_inc <= '0;
            r_ce  <= 1'b0;
        end else begin
            if (i_inc_we) r_inc <= i_inc;
            if (!i_en || i_align) begin
                r_acc <= '0;
                r_ce  <= 1'b0;
            end else begin
                r_acc <= w_sum[ACC_W-1:0];
                r_ce  <= w_sum[ACC_W];
            end
        end
    end

endmodule

// File: rtl/clk_strobe_gen.sv
// clk_strobe_gen: lock-qualified reset sequencer plus CHANNELS fractional clock-enable strobes.
module clk_strobe_gen
    import clkgen_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int ACC_W    = 24,
    parameter int LOCK_CNT = 1024
) (
    input  logic                      clkin,
    input  logic                      rst_n,
    input  logic                      pll_locked,
    input  logic [CHANNELS*ACC_W-1:0] inc,
    input  logic [CHANNELS-1:0]       inc_we,
    input  logic                      align,
    output logic [CHANNELS-1:0]       ce,
    output logic                      rst_out_n,
    output logic                      ready
);

    localparam int CNT_W = $clog2(LOCK_CNT);

    logic [1:0]       r_sync;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_ready;
    logic             r_rst_out_n;
    logic             w_lk_s;
    logic             w_run_nxt;

    assign w_lk_s    = r_sync[1];
    assign w_run_nxt = (w_state_nxt == RUN);
    assign ready     = r_ready;
    assign rst_out_n = r_rst_out_n;

    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            r_sync      <= '0;
            r_state     <= WAIT_LOCK;
            r_cnt       <= '0;
            r_ready     <= 1'b0;
            r_rst_out_n <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], pll_locked};
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ready     <= w_run_nxt;
            r_rst_out_n <= w_run_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            WAIT_LOCK: if (w_lk_s) w_state_nxt = COUNT;
            COUNT: begin
                if (!w_lk_s) w_state_nxt = WAIT_LOCK;
                else if (r_cnt == CNT_W'(LOCK_CNT - 1)) w_state_nxt = RUN;
                else w_cnt_nxt = r_cnt + 1'b1;
            end
            RUN: if (!w_lk_s) w_state_nxt = WAIT_LOCK;
            default: w_state_nxt = WAIT_LOCK;
        endcase
    end

    // Channels follow the next state so strobes stop on the same edge that reset drops
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        phase_acc #(.ACC_W(ACC_W)) u_acc (
            .clkin    (clkin),
            .rst_n    (rst_n),
            .i_en     (w_run_nxt),
            .i_align  (align),
            .i_inc_we (inc_we[i]),
            .i_inc    (inc[i*ACC_W +: ACC_W]),
            .o_ce     (ce[i])
        );
    end

endmodule

// File: tb/tb_clk_strobe_gen.sv
// tb_clk_strobe_gen: directed and random checks of clk_strobe_gen against a lock-streak / phase model.
module tb_clk_strobe_gen;
    import clkgen_pkg::*;

    localparam int CH = 3;
    localparam int W  = 24;
    localparam int LC = 16;

    logic          clkin = 1'b0;
    logic          rst_n = 1'b0;
    logic          pll_locked = 1'b0;
    logic          align = 1'b0;
    logic [CH*W-1:0] inc = '0;
    logic [CH-1:0] inc_we = '0;
    logic [CH-1:0] ce;
    logic          rst_out_n;
    logic          ready;

    int total = 0;
    int bad   = 0;

    bit              hist[$];
    int              streak = 0;
    bit              m_ready = 0;
    bit [CH-1:0]     m_ce = '0;
    longint unsigned m_phase[CH];
    logic [W-1:0]    m_inc[CH];

    always #5 clkin = ~clkin;

    clk_strobe_gen #(.CHANNELS(CH), .ACC_W(W), .LOCK_CNT(LC)) dut (
        .clkin      (clkin),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .inc        (inc),
        .inc_we     (inc_we),
        .align      (align),
        .ce         (ce),
        .rst_out_n  (rst_out_n),
        .ready      (ready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int got, input int lo, input int hi);
        total++;
        assert (got >= lo && got <= hi) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d..%0d", tag, got, lo, hi);
        end
    endtask

    // Release needs lock seen (two cycles late) on LC+1 consecutive edges; strobes are carries of a running phase
    task automatic model_edge();
        bit lk;
        longint unsigned old;
        if (!rst_n) begin
            hist.delete();
            streak  = 0;
            m_ready = 0;
            m_ce    = '0;
            for (int c = 0; c < CH; c++) begin
                m_phase[c] = 0;
                m_inc[c]   = '0;
            end
            return;
        end
        hist.push_back(pll_locked);
        if (hist.size() > 3) void'(hist.pop_front());
        lk = (hist.size() == 3) && hist[0];
        streak  = lk ? streak + 1 : 0;
        m_ready = (streak > LC);
        for (int c = 0; c < CH; c++) begin
            if (!m_ready || align) begin
                m_phase[c] = 0;
                m_ce[c]    = 0;
            end else begin
                old        = m_phase[c];
                m_phase[c] = m_phase[c] + longint'(m_inc[c]);
                m_ce[c]    = (m_phase[c] >> W) != (old >> W);
            end
            if (inc_we[c]) m_inc[c] = inc[c*W +: W];
        end
    endtask

    task automatic tick();
        @(posedge clkin);
        model_edge();
        @(negedge clkin);
        chk("ready", ready, m_ready);
        chk("rst_out_n", rst_out_n, m_ready);
        chk("ce", ce, m_ce);
    endtask

    task automatic set_inc(input int c, input logic [W-1:0] v);
        inc[c*W +: W] = v;
        inc_we[c]     = 1'b1;
    endtask

    initial begin
        int n;
        int cnt[CH];
        int last[CH];
        int perr[CH];
        int per[CH];
        bit early;
        bit seen;
        per = '{4, 2, 8};

        repeat (3) tick();
        rst_n = 1'b1;
        set_inc(0, W'(freq_to_inc(25, 100, W)));
        set_inc(1, W'(freq_to_inc(50, 100, W)));
        set_inc(2, W'(freq_to_inc(125, 1000, W)));
        tick();
        inc_we = '0;

        pll_locked = 1'b1;
        n = 0;
        early = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
            if (!ready) early |= |ce;
        end
        chk_rng("lock_latency", n, LC + 2, LC + 4);
        chk("ce_before_run", early, 0);

        for (int c = 0; c < CH; c++) begin
            cnt[c] = 0; last[c] = -1; perr[c] = 0;
        end
        for (int t = 1; t <= 1000; t++) begin
            tick();
            for (int c = 0; c < CH; c++) if (ce[c]) begin
                if (last[c] >= 0 && t - last[c] != per[c]) perr[c]++;
                last[c] = t;
                cnt[c]++;
            end
        end
        chk("ch0_count", cnt[0], 250);
        chk("ch1_count", cnt[1], 500);
        chk("ch2_count", cnt[2], 125);
        chk("period_errors", perr[0] + perr[1] + perr[2], 0);

        set_inc(0, 24'h555555);
        align = 1'b1;
        tick();
        inc_we = '0;
        align  = 1'b0;
        n = 0;
        repeat (3072) begin
            tick();
            n += int'(ce[0]);
        end
        chk_rng("frac_count", n, 1023, 1024);

        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        n = 1;
        while (ready && n < 10) begin
            tick();
            n++;
        end
        chk("loss_latency", n, 3);
        n = n - 1;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        chk_rng("reacquire_latency", n, LC + 2, LC + 4);
        n = 0;
        repeat (16) begin
            tick();
            n += int'(ce[1]);
        end
        chk("inc_retained_ch1", n, 8);

        pll_locked = 1'b0;
        repeat (5) tick();
        pll_locked = 1'b1;
        repeat (11) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        seen = 0;
        repeat (18) begin
            tick();
            seen |= ready;
        end
        chk("glitch_no_release", seen, 0);
        n = 18;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        chk_rng("glitch_full_relock", n, LC + 2, LC + 4);

        set_inc(0, 24'h800000);
        align = 1'b1;
        tick();
        inc_we = '0;
        align  = 1'b0;
        chk("align_all_ce_clear", ce, 0);
        tick();
        chk("align_ce0_n1", ce[0], 0);
        tick();
        chk("align_ce0_n2", ce[0], 1);

        repeat (3000) begin
            rst_n      = ($urandom_range(499) != 0);
            pll_locked = ($urandom_range(299) != 0);
            align      = ($urandom_range(39) == 0);
            inc_we     = ($urandom_range(9) == 0) ? CH'($urandom_range(7)) : '0;
            for (int c = 0; c < CH; c++) inc[c*W +: W] = W'($urandom);
            tick();
        end
        rst_n = 1'b1;
        align = 1'b0;
        inc_we = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
